// File: rtl/ifid_if.sv
// ---------------------------------------------------------------------------
// ifid_if : signal bundle between the fetch/IF-ID stage and its neighbours
//           (hazard unit, branch unit, instruction memory, decode stage).
//
//   master : the environment side; drives Stall, Flush, BranchTaken,
//            BranchTarget and InstrIn, and observes the stage outputs.
//   slave  : the ifid_stage side; receives the controls and instruction
//            data, and drives PCOut plus the IF/ID register outputs.
//
//   Stall         hold PC and IF/ID contents
//   Flush         squash IF/ID (insert bubble)
//   BranchTaken   redirect fetch to BranchTarget
//   BranchTarget  redirect address (low two bits ignored)
//   InstrIn       instruction memory data for PCOut
//   PCOut         current fetch address
//   InstrOut      IF/ID instruction
//   PCPlus4Out    IF/ID PC+4 of InstrOut
//   Imm16Out      InstrOut[15:0], registered
//   ExtendSignOut 1 = sign-extend, 0 = zero-extend Imm16Out
//   ValidOut      IF/ID holds a real instruction
// ---------------------------------------------------------------------------
interface ifid_if;
   logic        Stall;
   logic        Flush;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic [31:0] InstrIn;
   logic [31:0] PCOut;
   logic [31:0] InstrOut;
   logic [31:0] PCPlus4Out;
   logic [15:0] Imm16Out;
   logic        ExtendSignOut;
   logic        ValidOut;

   modport master (
      output Stall, Flush, BranchTaken, BranchTarget, InstrIn,
      input  PCOut, InstrOut, PCPlus4Out, Imm16Out, ExtendSignOut, ValidOut
   );

   modport slave (
      input  Stall, Flush, BranchTaken, BranchTarget, InstrIn,
      output PCOut, InstrOut, PCPlus4Out, Imm16Out, ExtendSignOut, ValidOut
   );
endinterface

// File: rtl/ifid_stage.sv
// ---------------------------------------------------------------------------
// ifid_stage : fetch PC register plus the IF/ID pipeline register.
//
// The PC is presented to instruction memory (PCOut), which returns InstrIn
// combinationally. On a normal edge the instruction, PC+4 and the
// pre-decoded 16-bit immediate with its extension mode are captured into
// IF/ID. After reset a short BOOT phase suppresses fetch while memory
// warms up; then RUN applies branch > flush > stall > fetch priority.
//
// Parameters:
//   RESET_PC     fetch address loaded on reset
//   BOOT_CYCLES  warm-up cycles after reset release (1..15)
//
// Ports:
//   Clk   rising-edge clock
//   Rst   asynchronous active-low reset
//   bus   ifid_if.slave (controls, InstrIn, PC and IF/ID outputs)
//
// Build option:
//   IFID_DELAY_SLOT_EN  when defined, a taken branch keeps the instruction
//                       in the delay slot (IF/ID loads or holds on Stall)
//                       instead of bubbling it.
// ---------------------------------------------------------------------------
module ifid_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BOOT_CYCLES = 2
) (
   input  logic Clk,
   input  logic Rst,
   ifid_if.slave bus
);

   typedef enum logic [0:0] {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg,   cnt_next;
   logic [31:0] pc_reg,    pc_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] pc4_reg,   pc4_next;
   logic [15:0] imm_reg,   imm_next;
   logic        ext_reg,   ext_next;
   logic        valid_reg, valid_next;

   logic [31:0] pc_plus4;
   logic [31:0] target_aligned;
   logic        fetch_ext;
   logic [1:0]  unused_target_lsb;

   assign pc_plus4          = pc_reg + 32'd4;   // wraps modulo 2^32
   assign target_aligned    = {bus.BranchTarget[31:2], 2'b00};
   assign unused_target_lsb = bus.BranchTarget[1:0];

   // Logical immediates (andi/ori/xori) are zero-extended; all else signed.
   always_comb begin
      fetch_ext = 1'b1;
      case (bus.InstrIn[31:26])
         6'h0C, 6'h0D, 6'h0E: fetch_ext = 1'b0;
         default:             fetch_ext = 1'b1;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_reg <= ST_BOOT;
         cnt_reg   <= 4'd0;
         pc_reg    <= RESET_PC;
         instr_reg <= 32'h0;
         pc4_reg   <= 32'h0;
         imm_reg   <= 16'h0;
         ext_reg   <= 1'b1;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pc_reg    <= pc_next;
         instr_reg <= instr_next;
         pc4_reg   <= pc4_next;
         imm_reg   <= imm_next;
         ext_reg   <= ext_next;
         valid_reg <= valid_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pc_next    = pc_reg;
      instr_next = instr_reg;
      pc4_next   = pc4_reg;
      imm_next   = imm_reg;
      ext_next   = ext_reg;
      valid_next = valid_reg;

      case (state_reg)
         ST_BOOT: begin
            // PC holds, controls ignored, IF/ID kept as a bubble.
            cnt_next   = cnt_reg + 4'd1;
            instr_next = 32'h0;
            pc4_next   = 32'h0;
            imm_next   = 16'h0;
            ext_next   = 1'b1;
            valid_next = 1'b0;
            if (cnt_reg == BOOT_LAST) begin
               state_next = ST_RUN;
               cnt_next   = 4'd0;
            end
         end

         ST_RUN: begin
            if (bus.BranchTaken) begin
               pc_next = target_aligned;
`ifdef IFID_DELAY_SLOT_EN
               // Delay slot instruction survives the redirect.
               if (!bus.Stall) begin
                  instr_next = bus.InstrIn;
                  pc4_next   = pc_plus4;
                  imm_next   = bus.InstrIn[15:0];
                  ext_next   = fetch_ext;
                  valid_next = 1'b1;
               end
`else
               instr_next = 32'h0;
               pc4_next   = 32'h0;
               imm_next   = 16'h0;
               ext_next   = 1'b1;
               valid_next = 1'b0;
`endif
            end else if (bus.Flush) begin
               pc_next    = pc_plus4;
               instr_next = 32'h0;
               pc4_next   = 32'h0;
               imm_next   = 16'h0;
               ext_next   = 1'b1;
               valid_next = 1'b0;
            end else if (!bus.Stall) begin
               pc_next    = pc_plus4;
               instr_next = bus.InstrIn;
               pc4_next   = pc_plus4;
               imm_next   = bus.InstrIn[15:0];
               ext_next   = fetch_ext;
               valid_next = 1'b1;
            end
         end

         default: begin
            state_next = ST_BOOT;
            cnt_next   = 4'd0;
         end
      endcase
   end

   assign bus.PCOut         = pc_reg;
   assign bus.InstrOut      = instr_reg;
   assign bus.PCPlus4Out    = pc4_reg;
   assign bus.Imm16Out      = imm_reg;
   assign bus.ExtendSignOut = ext_reg;
   assign bus.ValidOut      = valid_reg;

endmodule

// File: doc/ifid_stage.md
Name: ifid_stage

Overview:
- Instruction-fetch PC register plus the IF/ID pipeline register that feeds the decode stage.
- Holds the fetch PC and presents it to instruction memory, which returns the instruction combinationally.
- Latches the instruction and PC+4 into IF/ID, and pre-decodes the 16-bit immediate and its extension-mode flag consumed by sign_extension.
- Handles boot warm-up, stall, flush and branch redirect.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- BOOT_CYCLES, 2, cycles after reset release during which fetch is suppressed for memory warm-up; legal range 1..15.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-low reset (asserted when 0)
- Stall  input  1  hazard unit: hold PC and IF/ID contents
- Flush  input  1  squash the IF/ID contents (insert bubble)
- BranchTaken  input  1  redirect fetch to BranchTarget
- BranchTarget  input  32  redirect address, word aligned
- InstrIn  input  32  instruction memory data for PCOut
- PCOut  output  32  current fetch address
- InstrOut  output  32  IF/ID instruction
- PCPlus4Out  output  32  IF/ID PC+4 of InstrOut
- Imm16Out  output  16  InstrOut[15:0], registered
- ExtendSignOut  output  1  1 = sign-extend, 0 = zero-extend Imm16Out
- ValidOut  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (Rst=0, asynchronous):
  - PCOut=RESET_PC; InstrOut=0; PCPlus4Out=0; Imm16Out=0; ExtendSignOut=1; ValidOut=0.
  - FSM goes to BOOT; boot counter = 0.
- FSM BOOT:
  - Counter increments each cycle; PC holds; IF/ID is loaded with a bubble.
  - Stall, Flush and BranchTaken are ignored.
  - When the counter reaches BOOT_CYCLES-1, the next state is RUN.
- FSM RUN, per rising edge, in priority order:
  1. BranchTaken=1: PCOut<=BranchTarget; IF/ID<=bubble. Overrides Stall and Flush.
  2. Flush=1: PCOut<=PCOut+4; IF/ID<=bubble.
  3. Stall=1: PCOut and all IF/ID outputs hold.
  4. Otherwise: InstrOut<=InstrIn; PCPlus4Out<=PCOut+4; Imm16Out<=InstrIn[15:0]; ExtendSignOut<=decode(InstrIn); ValidOut<=1; PCOut<=PCOut+4.
- Bubble: InstrOut=32'h0 (sll $0 nop), PCPlus4Out=0, Imm16Out=0, ExtendSignOut=1, ValidOut=0.
- decode():
  - Opcode InstrIn[31:26] of 6'h0C (andi), 6'h0D (ori) or 6'h0E (xori) gives 0.
  - All other opcodes give 1.
- Latency: instruction at PCOut appears on InstrOut one edge later.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). BranchTarget[1:0] is forced to 00.
- Reset asserted mid-operation clears everything immediately, regardless of Stall or branch.

Optional Feature:
- Macro: IFID_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - On BranchTaken, IF/ID loads the current InstrIn normally (ValidOut=1) while PCOut<=BranchTarget.
  - If Stall=1 together with BranchTaken, IF/ID holds and PCOut<=BranchTarget.
  - Flush alone still bubbles.
- Undefined: BranchTaken bubbles IF/ID as specified above.

Test Plan:
- Reset release with RESET_PC=0, BOOT_CYCLES=2 -> ValidOut=0 and PCOut=0 for 2 edges; 3rd edge latches InstrIn, ValidOut=1, PCOut=4.
- InstrIn=32'h3508_8001 (ori), then 32'h2108_FFFF (addi) -> ExtendSignOut 0 then 1; Imm16Out 16'h8001 then 16'hFFFF; PCPlus4Out 4 then 8.
- Stall held 3 cycles at PCOut=8 -> PCOut, InstrOut and PCPlus4Out unchanged; 4th edge resumes with PCOut=12.
- BranchTaken=1, BranchTarget=32'h40, Stall=1 -> PCOut=32'h40 and ValidOut=0 (macro off); with macro on, IF/ID holds and PCOut=32'h40.
- PCOut=32'hFFFF_FFFC normal fetch -> PCOut=0, PCPlus4Out=0.
- Rst=0 pulsed between edges mid-run -> outputs reset values immediately and the BOOT sequence repeats.
